elm_hidden_seq: RTL and testbench

Sequencer for the ELM hidden-layer pass. It drives the sample counter COUNTERPM1 through en_P and rst_P, and consumes that counter's stop flag. For every training sample it steps through all hidden neurons and input features, issuing MAC, activation and H-matrix write strobes. Upstream it takes start/abort from the top controller; downstream it feeds the MAC/activation datapath and H memory, which are addressed by P_index, j_index and i_index.

---
 rtl/elm_pkg.sv | 19 +
 rtl/elm_loop_cnt.sv | 26 ++
 rtl/elm_hidden_seq.sv | 130 +++++++++++++
 tb/tb_elm_hidden_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared constants and state encoding for the ELM hidden-layer sequencer and its datapath.
package elm_pkg;

    localparam int N_IN    = 16;
    localparam int L_HID   = 64;
    localparam int ACT_LAT = 3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_INIT  = 3'd1;
    localparam state_t S_CLR   = 3'd2;
    localparam state_t S_MAC   = 3'd3;
    localparam state_t S_ACT   = 3'd4;
    localparam state_t S_WR    = 3'd5;
    localparam state_t S_NEXTP = 3'd6;
    localparam state_t S_DONE  = 3'd7;

endpackage

// File: rtl/elm_loop_cnt.sv
// Saturating loop up-counter with synchronous clear, enable and terminal flag.
module elm_loop_cnt #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         term
);

    assign term = (q == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !term) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/elm_hidden_seq.sv
// Hidden-layer pass sequencer: walks samples x neurons x features and strobes MAC,
// activation and H-write. Outputs are registered from the next-state decode.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | clear sample counter, reset loop indices
// CLR    | clear accumulator for neuron j
// MAC    | accumulate feature i (N_IN cycles)
// ACT    | activation in flight (ACT_LAT cycles)
// WR     | write H[P][j]
// NEXTP  | last neuron done; advance sample or finish
// DONE   | completion pulse
module elm_hidden_seq #(
    parameter int N_IN    = 16,
    parameter int L_HID   = 64,
    parameter int ACT_LAT = 3,
    parameter int I_W     = 4,
    parameter int J_W     = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           stop,
    output logic           en_P,
    output logic           rst_P,
    output logic [I_W-1:0] i_index,
    output logic [J_W-1:0] j_index,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           act_start,
    output logic           h_we,
    output logic           busy,
    output logic           done
);
    import elm_pkg::*;

    localparam int LAT_W = (ACT_LAT > 1) ? $clog2(ACT_LAT) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             aborting;
    logic             i_clr, i_en, i_term;
    logic             j_clr, j_en, j_term;
    logic             lat_clr, lat_en, lat_term;
    logic [LAT_W-1:0] unused_lat_cnt;

    assign aborting = abort && (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        if (aborting) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start && !abort) state_nxt = S_INIT;
                S_INIT:  state_nxt = S_CLR;
                S_CLR:   state_nxt = S_MAC;
                S_MAC:   if (i_term) state_nxt = S_ACT;
                S_ACT:   if (lat_term) state_nxt = S_WR;
                S_WR:    state_nxt = j_term ? S_NEXTP : S_CLR;
                S_NEXTP: state_nxt = stop ? S_DONE : S_CLR;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Indices are steered by the next state so they line up with the registered strobes.
    assign i_clr   = (state_nxt == S_IDLE) || (state_nxt == S_INIT) || (state_nxt == S_CLR);
    assign i_en    = (state == S_MAC) && (state_nxt == S_MAC);
    assign j_clr   = (state_nxt == S_IDLE) || (state_nxt == S_INIT) ||
                     ((state == S_NEXTP) && (state_nxt == S_CLR));
    assign j_en    = (state == S_WR) && (state_nxt == S_CLR);
    assign lat_clr = (state != S_ACT);
    assign lat_en  = (state == S_ACT);

    elm_loop_cnt #(.MAX(N_IN - 1), .W(I_W)) u_i_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (i_clr),
        .en   (i_en),
        .q    (i_index),
        .term (i_term)
    );

    elm_loop_cnt #(.MAX(L_HID - 1), .W(J_W)) u_j_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (j_clr),
        .en   (j_en),
        .q    (j_index),
        .term (j_term)
    );

    elm_loop_cnt #(.MAX(ACT_LAT - 1), .W(LAT_W)) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (lat_clr),
        .en   (lat_en),
        .q    (unused_lat_cnt),
        .term (lat_term)
    );

    // en_P lands in the CLR after NEXTP, so P moves before the next sample's first MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rst_P     <= 1'b0;
            en_P      <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            act_start <= 1'b0;
            h_we      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rst_P     <= (state_nxt == S_INIT) || aborting;
            en_P      <= (state == S_NEXTP) && (state_nxt == S_CLR);
            mac_clr   <= (state_nxt == S_CLR);
            mac_en    <= (state_nxt == S_MAC);
            act_start <= (state == S_MAC) && (state_nxt == S_ACT);
            h_we      <= (state_nxt == S_WR);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_elm_hidden_seq.sv
// Bench for elm_hidden_seq: cycle-by-cycle trace model of a pass plus a sample-counter model.
module tb_elm_hidden_seq;

    localparam int N_IN    = 4;
    localparam int L_HID   = 3;
    localparam int ACT_LAT = 2;
    localparam int I_W     = 2;
    localparam int J_W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic stop;
    logic en_P, rst_P, mac_clr, mac_en, act_start, h_we, busy, done;
    logic [I_W-1:0] i_index;
    logic [J_W-1:0] j_index;

    always #5 clk = ~clk;

    elm_hidden_seq #(
        .N_IN(N_IN), .L_HID(L_HID), .ACT_LAT(ACT_LAT), .I_W(I_W), .J_W(J_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stop(stop),
        .en_P(en_P), .rst_P(rst_P), .i_index(i_index), .j_index(j_index),
        .mac_clr(mac_clr), .mac_en(mac_en), .act_start(act_start),
        .h_we(h_we), .busy(busy), .done(done)
    );

    // COUNTERPM1 model
    int p_cnt;
    int n_samp = 2;
    always @(posedge clk or posedge rst) begin
        if (rst)        p_cnt <= 0;
        else if (rst_P) p_cnt <= 0;
        else if (en_P)  p_cnt <= p_cnt + 1;
    end
    assign stop = (p_cnt == n_samp - 1);

    // ctl = {rst_P, en_P, mac_clr, mac_en, act_start, h_we, busy, done}; -1 = don't care
    typedef struct {
        logic [7:0] ctl;
        int i;
        int j;
        int p;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    int cyc, done_cyc, n_hwe, n_enp, n_rstp, n_done;

    function automatic logic [7:0] mk(bit rp, bit ep, bit mc, bit me, bit as, bit hw, bit bz, bit dn);
        return {rp, ep, mc, me, as, hw, bz, dn};
    endfunction

    task automatic push(logic [7:0] c, int i, int j, int p);
        exp_t e;
        e.ctl = c; e.i = i; e.j = j; e.p = p;
        q.push_back(e);
    endtask

    task automatic build_pass(int s_n);
        push(mk(1,0,0,0,0,0,1,0), 0, 0, -1);
        for (int s = 0; s < s_n; s++) begin
            for (int jj = 0; jj < L_HID; jj++) begin
                push(mk(0, (s > 0 && jj == 0), 1,0,0,0,1,0), 0, jj, -1);
                for (int k = 0; k < N_IN; k++) push(mk(0,0,0,1,0,0,1,0), k, jj, s);
                for (int a = 0; a < ACT_LAT; a++) push(mk(0,0,0,0,(a == 0),0,1,0), N_IN-1, jj, -1);
                push(mk(0,0,0,0,0,1,1,0), N_IN-1, jj, s);
            end
            push(mk(0,0,0,0,0,0,1,0), N_IN-1, L_HID-1, -1);
        end
        push(mk(0,0,0,0,0,0,1,1), N_IN-1, L_HID-1, -1);
        push(8'h00, 0, 0, -1);
    endtask

    task automatic chk(string nm, int got, int exp_v);
        n_chk++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp_v);
        end
    endtask

    exp_t ce;
    logic [7:0] act_ctl;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            cyc++;
            act_ctl = {rst_P, en_P, mac_clr, mac_en, act_start, h_we, busy, done};
            n_chk++;
            if (act_ctl !== ce.ctl) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b", cyc, act_ctl, ce.ctl);
            end
            if (ce.i >= 0) begin
                n_chk++;
                if (int'(i_index) != ce.i) begin
                    n_fail++;
                    $display("FAIL i_index cyc=%0d got=%0d exp=%0d", cyc, i_index, ce.i);
                end
            end
            if (ce.j >= 0) begin
                n_chk++;
                if (int'(j_index) != ce.j) begin
                    n_fail++;
                    $display("FAIL j_index cyc=%0d got=%0d exp=%0d", cyc, j_index, ce.j);
                end
            end
            if (ce.p >= 0) begin
                n_chk++;
                if (p_cnt != ce.p) begin
                    n_fail++;
                    $display("FAIL p_index cyc=%0d got=%0d exp=%0d", cyc, p_cnt, ce.p);
                end
            end
            if (en_P) begin
                n_chk++;
                if (stop) begin
                    n_fail++;
                    $display("FAIL en_p_with_stop cyc=%0d got=1 exp=0", cyc);
                end
            end
            n_hwe  += int'(h_we);
            n_enp  += int'(en_P);
            n_rstp += int'(rst_P);
            n_done += int'(done);
            if (done && done_cyc == 0) done_cyc = cyc;
        end
    end

    task automatic clr_stats();
        cyc = 0; done_cyc = 0; n_hwe = 0; n_enp = 0; n_rstp = 0; n_done = 0;
    endtask

    task automatic start_pass(int s_n, bit hold);
        @(negedge clk);
        n_samp = s_n;
        clr_stats();
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        build_pass(s_n);
    endtask

    task automatic drain();
        for (int t = 0; t < 3000; t++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic chk_all_zero(string nm);
        chk(nm, int'({rst_P, en_P, mac_clr, mac_en, act_start, h_we, busy, done, i_index, j_index}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        clr_stats();
        #3;
        chk_all_zero("reset_outputs");
        #20;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // two-sample pass
        start_pass(2, 1'b0);
        drain();
        chk("s1_done_cyc", done_cyc, 52);
        chk("s1_h_we", n_hwe, 6);
        chk("s1_en_P", n_enp, 1);
        chk("s1_rst_P", n_rstp, 1);

        // single sample
        start_pass(1, 1'b0);
        drain();
        chk("s2_done_cyc", done_cyc, 27);
        chk("s2_h_we", n_hwe, 3);
        chk("s2_en_P", n_enp, 0);

        // abort during second MAC cycle of j=1
        start_pass(2, 1'b0);
        while (q.size() > 12) void'(q.pop_back());
        push(mk(1,0,0,0,0,0,0,0), 0, 0, -1);
        for (int k = 0; k < 3; k++) push(8'h00, 0, 0, -1);
        repeat (11) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        drain();
        chk("s4_done", n_done, 0);
        chk("s4_h_we", n_hwe, 1);
        chk("s4_rst_P", n_rstp, 2);

        // abort and start together in IDLE
        @(negedge clk);
        clr_stats();
        start = 1'b1;
        abort = 1'b1;
        for (int k = 0; k < 3; k++) push(8'h00, 0, 0, -1);
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        drain();
        chk("idle_abort_rst_P", n_rstp, 0);

        // start held through DONE: back-to-back passes
        start_pass(2, 1'b1);
        build_pass(2);
        push(8'h00, 0, 0, -1);
        repeat (60) @(posedge clk);
        #1 start = 1'b0;
        drain();
        chk("s5_done_cyc", done_cyc, 52);
        chk("s5_done", n_done, 2);
        chk("s5_rst_P", n_rstp, 2);
        chk("s5_en_P", n_enp, 2);
        chk("s5_h_we", n_hwe, 12);

        // async reset mid-ACT
        start_pass(2, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("s6_pre_act", int'(act_start), 1);
        chk("s6_pre_i", int'(i_index), N_IN - 1);
        q.delete();
        rst = 1'b1;
        #1;
        chk_all_zero("s6_async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_pass(2, 1'b0);
        drain();
        chk("s6_done_cyc", done_cyc, 52);
        chk("s6_h_we", n_hwe, 6);
        chk("s6_en_P", n_enp, 1);
        chk("s6_rst_P", n_rstp, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
